// File: rtl/lsb_queue_pkg.sv
// Shared op codes and tag constants for the in-order load/store queue.
// Imported by every lsb_queue file.
package lsb_queue_pkg;

  localparam int TAG_W_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 6;

  localparam logic [TAG_W_DEF-1:0] EMPTY_TAG = '0;

  typedef enum logic [OP_W_DEF-1:0] {
    OP_NOP = 6'd0,
    OP_LB  = 6'd1,
    OP_LH  = 6'd2,
    OP_LW  = 6'd3,
    OP_LBU = 6'd4,
    OP_LHU = 6'd5,
    OP_SB  = 6'd6,
    OP_SH  = 6'd7,
    OP_SW  = 6'd8
  } ls_op_e;

endpackage

// File: rtl/lsb_cdb_match.sv
// CDB_N-way tag compare against the result broadcast bus.
// Tag 0 never hits; the lowest matching channel supplies the data.
module lsb_cdb_match
  import lsb_queue_pkg::*;
#(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int CDB_N  = 2
) (
  input  logic [TAG_W-1:0]        i_tag,
  input  logic [CDB_N*TAG_W-1:0]  i_cdb_tag,
  input  logic [CDB_N*DATA_W-1:0] i_cdb_data,
  output logic                    o_hit,
  output logic [DATA_W-1:0]       o_data
);

  // Walk from the top so channel 0 is applied last.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int k = CDB_N - 1; k >= 0; k--) begin
      if ((i_tag != '0) &&
          (i_cdb_tag[k*TAG_W +: TAG_W] == i_tag)) begin
        o_hit  = 1'b1;
        o_data = i_cdb_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/lsb_queue.sv
// In-order load/store queue: circular FIFO with CDB snoop,
// store-commit gating and a flush that keeps committed stores.
module lsb_queue
  import lsb_queue_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int CDB_N  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    clear,
  output logic                    full,
  input  logic                    issue_en,
  input  logic [TAG_W-1:0]        issue_dest,
  input  logic [OP_W-1:0]         issue_op,
  input  logic                    issue_is_st,
  input  logic [TAG_W-1:0]        issue_q1,
  input  logic [TAG_W-1:0]        issue_q2,
  input  logic [DATA_W-1:0]       issue_v1,
  input  logic [DATA_W-1:0]       issue_v2,
  input  logic [31:0]             issue_imm,
  input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_N*DATA_W-1:0] cdb_data,
  input  logic                    commit_en,
  input  logic [TAG_W-1:0]        commit_tag,
  output logic                    ex_valid,
  input  logic                    ex_ready,
  output logic [OP_W-1:0]         ex_op,
  output logic [31:0]             ex_addr,
  output logic [DATA_W-1:0]       ex_wdata,
  output logic [TAG_W-1:0]        ex_tag
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_cmt;
  logic [DEPTH-1:0]  r_st;
  logic [TAG_W-1:0]  r_dest [DEPTH];
  logic [OP_W-1:0]   r_op   [DEPTH];
  logic [TAG_W-1:0]  r_q1   [DEPTH];
  logic [TAG_W-1:0]  r_q2   [DEPTH];
  logic [DATA_W-1:0] r_v1   [DEPTH];
  logic [DATA_W-1:0] r_v2   [DEPTH];
  logic [31:0]       r_imm  [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;

  logic              r_ex_valid;
  logic [OP_W-1:0]   r_ex_op;
  logic [31:0]       r_ex_addr;
  logic [DATA_W-1:0] r_ex_wdata;
  logic [TAG_W-1:0]  r_ex_tag;

  logic              w_hit1 [DEPTH];
  logic              w_hit2 [DEPTH];
  logic [DATA_W-1:0] w_d1   [DEPTH];
  logic [DATA_W-1:0] w_d2   [DEPTH];
  logic              w_ihit1;
  logic              w_ihit2;
  logic [DATA_W-1:0] w_id1;
  logic [DATA_W-1:0] w_id2;

  logic [AW-1:0]     w_h;
  logic [AW-1:0]     w_t;
  logic              w_full;
  logic              w_elig;
  logic              w_issue;
  logic              w_pop;
  logic [DEPTH-1:0]  w_cmt_hit;
  logic [DEPTH-1:0]  w_cmt_nx;
  logic [DEPTH-1:0]  w_keep;
  logic [PW-1:0]     w_surv;
  logic [AW-1:0]     w_idx;
  logic              w_run;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    lsb_cdb_match #(
      .TAG_W (TAG_W),
      .DATA_W(DATA_W),
      .CDB_N (CDB_N)
    ) u_m1 (
      .i_tag     (r_q1[g]),
      .i_cdb_tag (cdb_tag),
      .i_cdb_data(cdb_data),
      .o_hit     (w_hit1[g]),
      .o_data    (w_d1[g])
    );
    lsb_cdb_match #(
      .TAG_W (TAG_W),
      .DATA_W(DATA_W),
      .CDB_N (CDB_N)
    ) u_m2 (
      .i_tag     (r_q2[g]),
      .i_cdb_tag (cdb_tag),
      .i_cdb_data(cdb_data),
      .o_hit     (w_hit2[g]),
      .o_data    (w_d2[g])
    );
    assign w_cmt_hit[g] = commit_en && r_valid[g] &&
                          r_st[g] &&
                          (r_dest[g] == commit_tag);
  end

  lsb_cdb_match #(
    .TAG_W (TAG_W),
    .DATA_W(DATA_W),
    .CDB_N (CDB_N)
  ) u_iss1 (
    .i_tag     (issue_q1),
    .i_cdb_tag (cdb_tag),
    .i_cdb_data(cdb_data),
    .o_hit     (w_ihit1),
    .o_data    (w_id1)
  );

  lsb_cdb_match #(
    .TAG_W (TAG_W),
    .DATA_W(DATA_W),
    .CDB_N (CDB_N)
  ) u_iss2 (
    .i_tag     (issue_q2),
    .i_cdb_tag (cdb_tag),
    .i_cdb_data(cdb_data),
    .o_hit     (w_ihit2),
    .o_data    (w_id2)
  );

  assign w_h    = r_head[AW-1:0];
  assign w_t    = r_tail[AW-1:0];
  assign w_full = (r_head[AW] != r_tail[AW]) &&
                  (w_h == w_t);
  assign full   = w_full;

  assign w_elig = r_valid[w_h] && (r_q1[w_h] == '0) &&
                  (!r_st[w_h] ||
                   ((r_q2[w_h] == '0) && r_cmt[w_h]));

  assign w_cmt_nx = r_cmt | w_cmt_hit;
  assign w_issue  = issue_en && !w_full && !clear;

  // Survivors of a flush: committed stores contiguous from head.
  always_comb begin
    w_keep = '0;
    w_surv = '0;
    w_run  = 1'b1;
    w_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = w_h + AW'(i);
      if (w_run && r_valid[w_idx] && w_cmt_nx[w_idx]) begin
        w_keep[w_idx] = 1'b1;
        w_surv        = w_surv + PW'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  // A flushed in-flight load is abandoned, never popped.
  assign w_pop = r_ex_valid && ex_ready &&
                 (!clear || w_keep[w_h]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_cmt      <= '0;
      r_st       <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_addr  <= '0;
      r_ex_wdata <= '0;
      r_ex_tag   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dest[i] <= '0;
        r_op[i]   <= '0;
        r_q1[i]   <= '0;
        r_q2[i]   <= '0;
        r_v1[i]   <= '0;
        r_v2[i]   <= '0;
        r_imm[i]  <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && w_hit1[i]) begin
          r_q1[i] <= '0;
          r_v1[i] <= w_d1[i];
        end
        if (r_valid[i] && w_hit2[i]) begin
          r_q2[i] <= '0;
          r_v2[i] <= w_d2[i];
        end
        if (w_cmt_hit[i]) r_cmt[i] <= 1'b1;
      end

      if (clear) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!w_keep[i]) begin
            r_valid[i] <= 1'b0;
            r_cmt[i]   <= 1'b0;
          end
        end
        r_tail <= r_head + w_surv;
      end else if (w_issue) begin
        r_valid[w_t] <= 1'b1;
        r_cmt[w_t]   <= 1'b0;
        r_st[w_t]    <= issue_is_st;
        r_dest[w_t]  <= issue_dest;
        r_op[w_t]    <= issue_op;
        r_imm[w_t]   <= issue_imm;
        r_q1[w_t]    <= w_ihit1 ? '0 : issue_q1;
        r_q2[w_t]    <= w_ihit2 ? '0 : issue_q2;
        r_v1[w_t]    <= w_ihit1 ? w_id1 : issue_v1;
        r_v2[w_t]    <= w_ihit2 ? w_id2 : issue_v2;
        r_tail       <= r_tail + PW'(1);
      end

      if (w_pop) begin
        r_valid[w_h] <= 1'b0;
        r_cmt[w_h]   <= 1'b0;
        r_head       <= r_head + PW'(1);
      end

      if (r_ex_valid) begin
        if (ex_ready || (clear && !w_keep[w_h]))
          r_ex_valid <= 1'b0;
      end else if (!clear && w_elig) begin
        r_ex_valid <= 1'b1;
        r_ex_op    <= r_op[w_h];
        r_ex_addr  <= 32'(r_v1[w_h]) + r_imm[w_h];
        r_ex_wdata <= r_v2[w_h];
        r_ex_tag   <= r_dest[w_h];
      end
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_op    = r_ex_op;
  assign ex_addr  = r_ex_addr;
  assign ex_wdata = r_ex_wdata;
  assign ex_tag   = r_ex_tag;

endmodule

// File: tb/tb_lsb_queue.sv
// Directed self-checking bench for lsb_queue.
// Linear stimulus; immediate assertions at each check point.
module tb_lsb_queue;
  import lsb_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        full;
  logic        issue_en = 1'b0;
  logic [3:0]  issue_dest = '0;
  logic [5:0]  issue_op = '0;
  logic        issue_is_st = 1'b0;
  logic [3:0]  issue_q1 = '0;
  logic [3:0]  issue_q2 = '0;
  logic [31:0] issue_v1 = '0;
  logic [31:0] issue_v2 = '0;
  logic [31:0] issue_imm = '0;
  logic [7:0]  cdb_tag = '0;
  logic [63:0] cdb_data = '0;
  logic        commit_en = 1'b0;
  logic [3:0]  commit_tag = '0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [5:0]  ex_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_tag;

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  lsb_queue dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .clear      (clear),
    .full       (full),
    .issue_en   (issue_en),
    .issue_dest (issue_dest),
    .issue_op   (issue_op),
    .issue_is_st(issue_is_st),
    .issue_q1   (issue_q1),
    .issue_q2   (issue_q2),
    .issue_v1   (issue_v1),
    .issue_v2   (issue_v2),
    .issue_imm  (issue_imm),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .commit_en  (commit_en),
    .commit_tag (commit_tag),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_op      (ex_op),
    .ex_addr    (ex_addr),
    .ex_wdata   (ex_wdata),
    .ex_tag     (ex_tag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_issue(input logic [3:0] d,
                           input logic st,
                           input logic [3:0] q1,
                           input logic [31:0] v1,
                           input logic [3:0] q2,
                           input logic [31:0] v2,
                           input logic [31:0] imm);
    issue_en    = 1'b1;
    issue_dest  = d;
    issue_is_st = st;
    issue_op    = st ? OP_SW : OP_LW;
    issue_q1    = q1;
    issue_v1    = v1;
    issue_q2    = q2;
    issue_v2    = v2;
    issue_imm   = imm;
  endtask

  task automatic issue(input logic [3:0] d,
                       input logic st,
                       input logic [3:0] q1,
                       input logic [31:0] v1,
                       input logic [3:0] q2,
                       input logic [31:0] v2,
                       input logic [31:0] imm);
    set_issue(d, st, q1, v1, q2, v2, imm);
    tick();
    issue_en = 1'b0;
  endtask

  task automatic wait_ex(input int n);
    int c = 0;
    while (!ex_valid && c < n) begin
      tick();
      c++;
    end
    chk("ex_wait", {31'd0, ex_valid}, 32'd1);
  endtask

  task automatic take();
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
  endtask

  initial begin
    // 1: reset and a single ready load
    tick();
    tick();
    rst = 1'b0;
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_exv", {31'd0, ex_valid}, 32'd0);
    chk("rst_addr", ex_addr, 32'd0);
    chk("rst_tag", {28'd0, ex_tag}, 32'd0);

    issue(4'd1, 1'b0, 4'd0, 32'h100, 4'd0, 32'd0, 32'd4);
    chk("lw_cyc1", {31'd0, ex_valid}, 32'd0);
    tick();
    chk("lw_cyc2", {31'd0, ex_valid}, 32'd1);
    chk("lw_addr", ex_addr, 32'h104);
    chk("lw_tag", {28'd0, ex_tag}, 32'd1);
    chk("lw_op", {26'd0, ex_op}, 32'(OP_LW));
    take();
    chk("lw_drop", {31'd0, ex_valid}, 32'd0);
    tick();
    tick();
    chk("lw_empty", {31'd0, ex_valid}, 32'd0);

    // 2: store waits on CDB ch1 and on commit
    issue(4'd2, 1'b1, 4'd0, 32'h200, 4'd5, 32'd0, 32'd8);
    cdb_tag[7:4]    = 4'd5;
    cdb_data[63:32] = 32'hAB;
    tick();
    cdb_tag = '0;
    cdb_data = '0;
    commit_en = 1'b1;
    commit_tag = 4'd9;
    tick();
    commit_en = 1'b0;
    tick();
    tick();
    chk("sw_nocmt", {31'd0, ex_valid}, 32'd0);
    commit_en = 1'b1;
    commit_tag = 4'd2;
    tick();
    commit_en = 1'b0;
    chk("sw_cmt0", {31'd0, ex_valid}, 32'd0);
    tick();
    chk("sw_valid", {31'd0, ex_valid}, 32'd1);
    chk("sw_wdata", ex_wdata, 32'hAB);
    chk("sw_addr", ex_addr, 32'h208);
    chk("sw_tag", {28'd0, ex_tag}, 32'd2);
    take();

    // 3: fill, overflow, drain, then wrap
    for (int i = 0; i < 16; i++) begin
      set_issue(4'(i), 1'b0, 4'd7, 32'd0, 4'd0, 32'd0,
                32'(i * 4));
      tick();
    end
    issue_en = 1'b0;
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_exv", {31'd0, ex_valid}, 32'd0);
    issue(4'hE, 1'b0, 4'd0, 32'h9999_0000, 4'd0, 32'd0,
          32'd0);
    chk("ovf_full", {31'd0, full}, 32'd1);
    cdb_tag[3:0]    = 4'd7;
    cdb_data[31:0]  = 32'h4000;
    tick();
    cdb_tag = '0;
    cdb_data = '0;
    wait_ex(5);
    chk("fill_0", ex_addr, 32'h4000);
    take();
    chk("pop_full", {31'd0, full}, 32'd0);
    for (int i = 1; i < 16; i++) begin
      wait_ex(5);
      chk("fill_ord", ex_addr, 32'h4000 + 32'(i * 4));
      take();
    end
    tick();
    tick();
    chk("ovf_gone", {31'd0, ex_valid}, 32'd0);

    for (int k = 0; k < 2; k++) begin
      issue(4'(k), 1'b0, 4'd0, 32'd0, 4'd0, 32'd0,
            32'(k * 16));
      exp_q.push_back(32'(k * 16));
    end
    for (int k = 0; k < 40; k++) begin
      wait_ex(5);
      chk("wrap_ord", ex_addr, exp_q.pop_front());
      ex_ready = 1'b1;
      if (k < 38) begin
        set_issue(4'(k), 1'b0, 4'd0, 32'd0, 4'd0, 32'd0,
                  32'((k + 2) * 16));
        exp_q.push_back(32'((k + 2) * 16));
      end
      tick();
      ex_ready = 1'b0;
      issue_en = 1'b0;
    end

    // 4: flush keeps only the committed store
    issue(4'd3, 1'b1, 4'd0, 32'h300, 4'd6, 32'd0, 32'h10);
    issue(4'd4, 1'b1, 4'd0, 32'h400, 4'd0, 32'h44, 32'd0);
    issue(4'd5, 1'b0, 4'd0, 32'h500, 4'd0, 32'd0, 32'd0);
    clear = 1'b1;
    commit_en = 1'b1;
    commit_tag = 4'd3;
    tick();
    clear = 1'b0;
    commit_en = 1'b0;
    chk("clr_exv", {31'd0, ex_valid}, 32'd0);
    for (int i = 0; i < 14; i++) begin
      set_issue(4'hD, 1'b0, 4'd7, 32'd0, 4'd0, 32'd0,
                32'(i * 4));
      tick();
    end
    issue_en = 1'b0;
    chk("clr_cnt15", {31'd0, full}, 32'd0);
    issue(4'hD, 1'b0, 4'd7, 32'd0, 4'd0, 32'd0, 32'd56);
    chk("clr_cnt16", {31'd0, full}, 32'd1);
    cdb_tag[3:0]   = 4'd6;
    cdb_data[31:0] = 32'h66;
    tick();
    cdb_tag = '0;
    cdb_data = '0;
    wait_ex(5);
    chk("clr_tag", {28'd0, ex_tag}, 32'd3);
    chk("clr_wdata", ex_wdata, 32'h66);
    chk("clr_addr", ex_addr, 32'h310);
    take();
    cdb_tag[3:0] = 4'd7;
    tick();
    cdb_tag = '0;
    for (int i = 0; i < 15; i++) begin
      wait_ex(5);
      chk("clr_drain", ex_addr, 32'(i * 4));
      take();
    end
    tick();
    tick();
    chk("clr_dropped", {31'd0, ex_valid}, 32'd0);

    // 5: backpressure and global stall
    issue(4'd8, 1'b0, 4'd0, 32'h1000, 4'd0, 32'd0, 32'h20);
    wait_ex(5);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_v", {31'd0, ex_valid}, 32'd1);
      chk("hold_addr", ex_addr, 32'h1020);
      chk("hold_tag", {28'd0, ex_tag}, 32'd8);
    end
    rdy = 1'b0;
    ex_ready = 1'b1;
    set_issue(4'hF, 1'b0, 4'd0, 32'd0, 4'd0, 32'd0, 32'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_v", {31'd0, ex_valid}, 32'd1);
      chk("stall_addr", ex_addr, 32'h1020);
    end
    rdy = 1'b1;
    issue_en = 1'b0;
    tick();
    ex_ready = 1'b0;
    chk("stall_pop", {31'd0, ex_valid}, 32'd0);
    tick();
    tick();
    chk("stall_noiss", {31'd0, ex_valid}, 32'd0);

    // 6: channel priority and issue-cycle bypass
    issue(4'd9, 1'b0, 4'hA, 32'd0, 4'd0, 32'd0, 32'd0);
    cdb_tag  = {4'hA, 4'hA};
    cdb_data = {32'h20, 32'h10};
    tick();
    cdb_tag = '0;
    cdb_data = '0;
    wait_ex(5);
    chk("prio_addr", ex_addr, 32'h10);
    take();
    set_issue(4'hB, 1'b0, 4'hC, 32'd0, 4'd0, 32'd0, 32'd4);
    cdb_tag[7:4]    = 4'hC;
    cdb_data[63:32] = 32'h500;
    tick();
    issue_en = 1'b0;
    cdb_tag = '0;
    cdb_data = '0;
    tick();
    chk("byp_v", {31'd0, ex_valid}, 32'd1);
    chk("byp_addr", ex_addr, 32'h504);
    chk("byp_tag", {28'd0, ex_tag}, 32'hB);
    take();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
